// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory port among N_REQ requesters.
// One transaction in flight at a time: IDLE (arbitrate) -> ISSUE (hold request) -> RESP (done).
// Optional mem_ack watchdog is compiled in when the macro ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [PTR_W-1:0]    winner;
  logic                winner_vld;
  logic [PTR_W-1:0]    cand;
  logic                timeout;
  logic                err_flag;

  // Unpack the per-requester address/data buses so they can be indexed by owner
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ?
                                  ($clog2(TIMEOUT_CYCLES) + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_flag = err_q;

  // Watchdog: count ISSUE cycles; err remembers whether ISSUE ended by timeout
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StIssue) begin
      cnt_d = cnt_q + CNT_W'(1);
      err_d = timeout && !mem_ack;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout  = 1'b0;
  assign err_flag = 1'b0;
`endif

  // Round-robin search: first set req bit starting at ptr, wrapping modulo N_REQ
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % N_REQ);
      if (!winner_vld && req[cand]) begin
        winner     = cand;
        winner_vld = 1'b1;
      end
    end
  end

  // FSM next state, transaction latching and all requester/memory-side strobes
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt     = '0;
    done    = '0;
    err     = '0;
    mem_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (winner_vld) begin
          owner_d = winner;
          we_d    = req_we[winner];
          addr_d  = addr_arr[winner];
          wdata_d = wdata_arr[winner];
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_req      = 1'b1;
        gnt[owner_q] = 1'b1;
        // A real ack beats a simultaneous timeout
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = DATA_W'(32'hDEAD_BEEF);
          state_d = StResp;
        end
      end
      StResp: begin
        gnt[owner_q]  = 1'b1;
        done[owner_q] = 1'b1;
        err[owner_q]  = err_flag;
        ptr_d         = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-transaction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (N_REQ=2): vector table plus scoreboard,
// with hand-written sequences for zero-wait, reset mid-transaction and timeout.
module tb_mem_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, done, err;
  logic [DW-1:0]   rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  int checks = 0;
  int errors = 0;

  int mem_lat   = 0;
  int mem_cnt   = 0;
  bit mem_mute  = 1'b0;
  bit stray_ack = 1'b0;

  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    int          lat;
    int          first;
    bit          scramble;
    bit          drop;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  mem_bus_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hCAFE_0101;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return 2'b01 << i;
  endfunction

  function automatic exp_t mk(input int o, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic e);
    exp_t x;
    x.owner = o;
    x.we    = we;
    x.addr  = a;
    x.wdata = d;
    x.err   = e;
    x.rdata = e ? 32'hDEAD_BEEF : mem_fn(a);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Memory model: acks mem_lat cycles after mem_req rises, data derived from address
  initial begin : mem_model
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (reset) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else if (!mem_req) begin
        mem_ack = stray_ack;
        mem_cnt = 0;
      end else begin
        if (!mem_mute && mem_cnt == mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_fn(mem_addr);
        end else begin
          mem_ack = 1'b0;
        end
        mem_cnt++;
      end
    end
  end

  // Monitor: ISSUE cycles checked against the scoreboard head, done pops and compares
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            check("mem_addr", mem_addr, sb[0].addr);
            check("mem_we", mem_we, sb[0].we);
            if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
            check("gnt_issue", gnt, oh(sb[0].owner));
            check("busy_issue", busy, 1);
          end
        end
        if (done != '0) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            x = sb.pop_front();
            check("done", done, oh(x.owner));
            check("gnt_resp", gnt, oh(x.owner));
            check("err", err, x.err ? oh(x.owner) : 2'b00);
            if (!x.we) check("rdata", rdata, x.rdata);
            check("mem_req_resp", mem_req, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    vec_t v;
    int   rem, cyc, o, nd;
    bit   seen;

    //            req    we     a0          a1          d0            d1            lat f  scr drp
    vecs[0] = '{2'b01, 2'b00, 32'h100,   32'h0,      32'h0,        32'h0,        2, 0, 0, 0};
    vecs[1] = '{2'b10, 2'b10, 32'h0,     32'h2000,   32'h0,        32'hA5A5A5A5, 2, 1, 1, 0};
    vecs[2] = '{2'b11, 2'b00, 32'h300,   32'h400,    32'h0,        32'h0,        0, 0, 0, 0};
    vecs[3] = '{2'b10, 2'b00, 32'h0,     32'h500,    32'h0,        32'h0,        3, 1, 0, 1};
    vecs[4] = '{2'b11, 2'b01, 32'h600,   32'h700,    32'h11112222, 32'h0,        1, 0, 1, 0};
    vecs[5] = '{2'b01, 2'b00, 32'h800,   32'h0,      32'h0,        32'h0,        0, 0, 0, 0};
    vecs[6] = '{2'b11, 2'b10, 32'h900,   32'hA00,    32'h0,        32'h3333,     2, 1, 0, 0};
    vecs[7] = '{2'b11, 2'b11, 32'hB00,   32'hC00,    32'h4444,     32'h5555,     1, 1, 0, 0};

    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Table-driven transactions
    for (int r = 0; r < 8; r++) begin
      v = vecs[r];
      @(negedge clk);
      mem_lat   = v.lat;
      req_we    = v.we;
      req_addr  = {v.a1, v.a0};
      req_wdata = {v.d1, v.d0};
      rem = 0;
      for (int k = 0; k < 2; k++) begin
        o = (k == 0) ? v.first : 1 - v.first;
        if (v.req[o]) begin
          sb.push_back(mk(o, v.we[o], (o == 1) ? v.a1 : v.a0, (o == 1) ? v.d1 : v.d0, 1'b0));
          rem++;
        end
      end
      req = v.req;
      cyc = 0;
      while (rem > 0 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (done[i]) begin
            req[i] = 1'b0;
            rem--;
          end else if (mem_req && gnt[i]) begin
            if (v.drop) req[i] = 1'b0;
            if (v.scramble) begin
              req_addr[i*32 +: 32]  = $urandom;
              req_wdata[i*32 +: 32] = $urandom;
            end
          end
        end
      end
      if (rem > 0) fail_now("row_done_wait");
      @(negedge clk);
      check("row_idle_gnt", gnt, 0);
      check("row_idle_busy", busy, 0);
    end

    // mem_ack while idle must be ignored; rdata keeps the last write's captured value
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_busy", busy, 0);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_rdata", rdata, mem_fn(32'hB00));
    check("stray_busy2", busy, 0);

    // Zero-wait memory, single requester held: done at cycles 2, 5, 8
    @(negedge clk);
    mem_lat = 0; req_we = '0; req_addr = {32'h0, 32'h1000};
    for (int k = 0; k < 3; k++) sb.push_back(mk(0, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 1'b0));
    req = 2'b01;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done[0]) begin
        check("zw_done_cycle", c, 2 + 3 * nd);
        nd++;
        if (nd < 3) req_addr[31:0] = 32'h1000 + 32'(4 * nd);
        else req = '0;
      end
    end
    check("zw_done_count", nd, 3);

    // Reset during ISSUE; ptr is 1 here so core 0 winning afterwards proves ptr reset
    @(negedge clk);
    mem_lat = 6; req_addr = {32'h0, 32'hD00};
    sb.push_back(mk(0, 1'b0, 32'hD00, 32'h0, 1'b0));
    req = 2'b01;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdata", rdata, 0);
    sb.delete();
    req = '0;
    @(negedge clk);
    reset = 1'b0;

    // Both held active for 8 transactions: strict alternation starting at core 0
    mem_lat = 1; req_we = '0; req_addr = {32'hF00, 32'hE00};
    for (int k = 0; k < 8; k++) sb.push_back(mk(k % 2, 1'b0, (k % 2) ? 32'hF00 : 32'hE00,
                                                32'h0, 1'b0));
    req = 2'b11;
    nd = 0; cyc = 0;
    while (nd < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        nd++;
        if (nd == 8) req = '0;
      end
    end
    check("alt_count", nd, 8);

`ifdef ARB_TIMEOUT_EN
    // No ack: done+err after 16 ISSUE cycles, then normal service resumes
    @(negedge clk);
    mem_mute = 1'b1; req_addr = {32'h1100, 32'h1200};
    sb.push_back(mk(1, 1'b0, 32'h1100, 32'h0, 1'b1));
    req = 2'b10;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done[1] && !seen) begin
        check("to_done_cycle", c, TO + 1);
        seen = 1'b1;
        req  = '0;
      end
    end
    check("to_seen", seen, 1);
    mem_mute = 1'b0; mem_lat = 1;
    sb.push_back(mk(0, 1'b0, 32'h1200, 32'h0, 1'b0));
    req = 2'b01;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done[0] && !seen) begin
        check("after_to_cycle", c, 3);
        seen = 1'b1;
        req  = '0;
      end
    end
    check("after_to_seen", seen, 1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between N_REQ per-core cache controllers in the multicore RISC-V system.
- Uses round-robin arbitration. Exactly one transaction is in flight at a time.
- Latches the winner's request and holds it on the memory side until the memory acknowledges. Then it returns read data and a one-cycle done pulse to the winner.
- Sits between the per-core cache controllers (upstream) and the memory model (downstream).

Parameters:
- N_REQ, 2, number of requesters (cores); legal range 2..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for mem_ack; only used with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until that requester's done.
- req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  N_REQ*DATA_W  packed write data; requester i occupies slice i.
- gnt  out  N_REQ  one-hot grant, high from ISSUE through RESP.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  N_REQ  completion error flag, valid with done.
- rdata  out  DATA_W  read data returned to the owner, valid while done is high.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer goes to 0.
  - A transaction in flight is dropped; mem_req falls in the same cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req bit is high, choose the winner: the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Latch the winner index, req_we, req_addr and req_wdata into registers.
  - Next state is ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE:
  - mem_req = 1, and gnt[owner] = 1.
  - mem_we, mem_addr and mem_wdata come from the latched registers. They are stable for the whole of ISSUE and ignore any input change.
  - When mem_ack is sampled high:
    - Capture mem_rdata into rdata (write transactions also capture it, and the value is don't-care).
    - Next state is RESP.
  - mem_req is 0 in RESP.
- RESP:
  - done[owner] = 1 and gnt[owner] = 1 for exactly one cycle.
  - ptr is set to (owner+1) mod N_REQ.
  - Next state is IDLE.
  - rdata holds its value until the next capture.
- Requester contract:
  - The requester drops req on the edge that ends RESP, so it is not re-arbitrated in the following IDLE cycle.
  - If req drops during ISSUE, the transaction still completes and done still pulses (memory cannot abort).
- Latency:
  - req is sampled at edge t.
  - mem_req is high in the cycle after edge t.
  - The earliest mem_ack is sampled at edge t+1.
  - done is high in the cycle after edge t+1.
  - The next IDLE starts after edge t+2.
  - Minimum back-to-back issue rate is one transaction per 3 cycles.
- Simultaneous requests: the pointer rotates on every completion, so with all N_REQ requesters active each one is served within N_REQ transactions (no starvation).
- mem_ack outside ISSUE is ignored.
- Arithmetic: ptr and owner are $clog2(N_REQ) bits wide. Wrap is an explicit modulo N_REQ, which is required when N_REQ is not a power of two.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit (or wider) counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If the count reaches TIMEOUT_CYCLES-1 without mem_ack, move to RESP with err[owner] = 1 and rdata = 32'hDEADBEEF (truncated or extended to DATA_W).
  - mem_req drops in RESP.
  - If mem_ack arrives in the same cycle as the timeout, mem_ack wins and err = 0.
- Without the macro: ISSUE waits indefinitely, err is tied to 0, and no counter exists.

Test Plan:
- Single read: req[0]=1, req_we=0, addr 0x100; memory acks 2 cycles after mem_req with rdata 0xCAFE0001 -> mem_addr=0x100 while mem_req is high; done[0] one cycle; rdata=0xCAFE0001; err=0; gnt returns to 0.
- Contention: req=2'b11 from reset -> core 0 served first, then core 1, with mem_addr sequence addr0, addr1. Repeated 4 times with both requesters held active -> strict alternation 0,1,0,1,...
- Write stability: core 1 writes 0xA5A5A5A5 to 0x2000; its req_addr and req_wdata change during ISSUE -> mem_addr and mem_wdata stay 0x2000 and 0xA5A5A5A5 until mem_ack.
- Reset mid-transaction: assert reset during ISSUE -> mem_req, gnt and busy go to 0 immediately. After release, req=2'b11 -> core 0 is granted first (ptr reset to 0).
- Zero-wait memory: mem_ack in the first ISSUE cycle -> done exactly 2 cycles after req is sampled; three consecutive single-requester transactions complete at a 3-cycle spacing.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no mem_ack -> done and err pulse after 16 ISSUE cycles with rdata=0xDEADBEEF; the next requester is then served normally.
